// File: rtl/symbol_draw_ctrl_if.sv
// Draw-request handshake bundle for symbol_draw_ctrl.
// master: requester (valid/col/row/sym out, ready in); slave: controller.
interface symbol_draw_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_col;
  logic [2:0] req_row;
  logic       req_sym;

  modport master (
    output req_valid, req_col, req_row, req_sym,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_col, req_row, req_sym,
    output req_ready
  );
endinterface

// File: rtl/symbol_draw_ctrl.sv
// Symbol draw sequencer: cell request -> generator run, pixel mux to VGA,
// black board-clear sweep. Ports: clk/reset, clear_req, req (handshake),
// generator control (sym_sel, draw_go, draw_x/y) and stream (gen_*),
// VGA write port (vga_*), status (busy, done, err).
module symbol_draw_ctrl #(
  parameter int COLS    = 3,
  parameter int ROWS    = 3,
  parameter int CELL_W  = 16,
  parameter int CELL_H  = 16,
  parameter int X0      = 40,
  parameter int Y0      = 20,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  symbol_draw_ctrl_if.slave req,
  output logic       sym_sel,
  output logic       draw_go,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  input  logic [7:0] gen_x,
  input  logic [6:0] gen_y,
  input  logic [2:0] gen_colour,
  input  logic       gen_next,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [15:0] CX_LAST = 16'(COLS * CELL_W - 1);
  localparam logic [15:0] CY_LAST = 16'(ROWS * CELL_H - 1);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_GAP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] cx;
  logic [15:0] cy;
  logic [15:0] wd;
  logic [7:0]  hold_x;
  logic [6:0]  hold_y;
  logic        accept;
  logic        in_range;
  logic        clr_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    in_range      = (int'(req.req_col) < COLS) &&
                    (int'(req.req_row) < ROWS);
    accept        = 1'b0;
    req.req_ready = 1'b0;
    clr_last      = (cx == CX_LAST) && (cy == CY_LAST);
    draw_go       = 1'b0;
    vga_plot      = 1'b0;
    vga_x         = hold_x;
    vga_y         = hold_y;
    vga_colour    = 3'b000;
    busy          = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy          = 1'b0;
        req.req_ready = !clear_req;
        accept        = req.req_valid && !clear_req;
        if (clear_req)
          state_n = S_CLEAR;
        else if (accept && in_range)
          state_n = S_DRAW;
      end
      S_CLEAR: begin
        vga_plot = 1'b1;
        vga_x    = 8'(X0 + int'(cx));
        vga_y    = 7'(Y0 + int'(cy));
        if (clr_last) state_n = S_GAP;
      end
      S_DRAW: begin
        draw_go    = 1'b1;
        vga_plot   = 1'b1;
        vga_x      = gen_x;
        vga_y      = gen_y;
        vga_colour = gen_colour;
        if (gen_next || wd == WD_LAST)
          state_n = S_GAP;
      end
      S_GAP: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outside the plotting states the VGA coordinates replay the last
  // plotted pixel, so the held copy tracks whatever was last driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx      <= '0;
      cy      <= '0;
      wd      <= '0;
      hold_x  <= '0;
      hold_y  <= '0;
      draw_x  <= '0;
      draw_y  <= '0;
      sym_sel <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (vga_plot) begin
        hold_x <= vga_x;
        hold_y <= vga_y;
      end
      unique case (state)
        S_IDLE: begin
          cx <= '0;
          cy <= '0;
          wd <= '0;
          if (accept && in_range) begin
            draw_x  <= 8'(X0 + int'(req.req_col) * CELL_W);
            draw_y  <= 7'(Y0 + int'(req.req_row) * CELL_H);
            sym_sel <= req.req_sym;
          end else if (accept) begin
            err <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cx == CX_LAST) begin
            cx <= '0;
            cy <= cy + 16'd1;
          end else begin
            cx <= cx + 16'd1;
          end
          if (clr_last) done <= 1'b1;
        end
        S_DRAW: begin
          wd <= wd + 16'd1;
          if (gen_next)
            done <= 1'b1;
          else if (wd == WD_LAST)
            err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/symbol_draw_ctrl.md
# symbol_draw_ctrl

Sequencer that sits directly upstream of the per-symbol pixel generators and in front of the VGA adapter. It accepts "draw symbol S in board cell (col,row)" requests, converts the cell to a base pixel coordinate, and drives the generator's run/base inputs until the generator reports completion. It muxes the generator's pixel stream onto the VGA write port, and also performs a full-board clear sweep in black.

## Interface
- COLS, 3, board columns (1..8)
- ROWS, 3, board rows (1..8)
- CELL_W, 16, cell width in pixels
- CELL_H, 16, cell height in pixels
- X0, 40, board left edge (pixels)
- Y0, 20, board top edge (pixels)
- TIMEOUT, 64, max DRAW cycles before abort
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- clear_req  in  1  level request for a board clear sweep
- req_valid  in  1  draw request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_col  in  3  target column
- req_row  in  3  target row
- req_sym  in  1  symbol select, 0 = generator A, 1 = generator B
- sym_sel  out  1  registered req_sym, selects generator
- draw_go  out  1  generator run/enable; generator counts while high, resets while low
- draw_x  out  8  base x to generator
- draw_y  out  7  base y to generator
- gen_x  in  8  generator pixel x (selected generator)
- gen_y  in  7  generator pixel y
- gen_colour  in  3  generator pixel colour
- gen_next  in  1  generator completion flag
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y
- vga_colour  out  3  pixel colour
- vga_plot  out  1  VGA write enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a draw or clear finishes
- err  out  1  one-cycle pulse on an out-of-range request or a timeout

## Operation
- States: IDLE, CLEAR, DRAW, GAP.
- IDLE: req_ready = !clear_req.
  - clear_req has priority over req_valid: with clear_req=1 the next state is CLEAR.
  - On accept with col<COLS and row<ROWS:
    - register draw_x = X0 + col*CELL_W and draw_y = Y0 + row*CELL_H, truncated to 8/7 bits (wrap, no saturation);
    - register sym_sel = req_sym;
    - next state is DRAW.
  - On accept with col>=COLS or row>=ROWS: pulse err, drop the request, stay in IDLE, leave draw_x/draw_y unchanged.
- CLEAR: internal counters cx in 0..COLS*CELL_W-1 and cy in 0..ROWS*CELL_H-1, raster order (cx fastest).
  - Each cycle: vga_x = X0+cx, vga_y = Y0+cy, vga_colour = 000, vga_plot = 1.
  - After the last pixel: go to GAP and pulse done.
  - clear_req is sampled only in IDLE; deasserting it mid-sweep has no effect.
- DRAW: draw_go = 1, vga_x/y/colour = gen_x/y/colour (combinational pass-through), vga_plot = 1.
  - gen_next=1: go to GAP and pulse done.
  - Watchdog counter reaches TIMEOUT-1 without gen_next: go to GAP and pulse err (no done).
- GAP: exactly one cycle with draw_go = 0 and vga_plot = 0 so the generator counter clears; then IDLE.
- Outside CLEAR and DRAW: vga_plot = 0, vga_colour = 000, vga_x/y hold their last value.
- Reset (asynchronous, any state): state IDLE; all outputs 0 except req_ready (= !clear_req); the in-flight draw or clear is abandoned, nothing completes after reset.

## Timing
- Accept edge N: DRAW from N+1, draw_go high N+1 onward.
- gen_next sampled high at edge M: done high in cycle M+1 (GAP), draw_go low in M+1, req_ready high in M+2 (if clear_req=0).
- Clear latency: COLS*CELL_W*ROWS*CELL_H plot cycles + 1 GAP cycle. Defaults: 2304 + 1.
- Minimum spacing between two accepted draws: draw length + 2 cycles.
- done and err are never high in the same cycle.
- vga_plot is high only in CLEAR and DRAW.

## Test plan
- Reset mid-DRAW: all outputs zero in the same cycle as reset rises; after release, state IDLE and req_ready=1.
- Draw col=2, row=1, sym=0; generator model asserts gen_next on its 52nd run cycle → draw_x=72, draw_y=36, draw_go high 52 cycles, vga_plot follows, done one cycle later, then 1-cycle GAP.
- Request col=3, row=0 → err pulse, req_ready stays 1, no draw_go, draw_x/draw_y unchanged.
- clear_req and req_valid high together in IDLE → CLEAR wins:
  - 2304 plot cycles, first pixel (40,20), last pixel (87,67), colour 000;
  - then done; then the draw is accepted.
- Generator model never asserts gen_next → draw_go high exactly 64 cycles, err pulse, no done, back to IDLE.
- X0=250, col=1 → draw_x = (250+16) mod 256 = 10 (wrap checked).
